// File: rtl/exe_operand_stage.sv
// ID/EX pipeline register and EX-stage operand network.
// Forwards MEM/WB results into the ALU operands and store data.
module exe_operand_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        d_valid,
    input  logic        d_wreg,
    input  logic        d_m2reg,
    input  logic        d_wmem,
    input  logic        d_aluimm,
    input  logic        d_shift,
    input  logic        d_jal,
    input  logic [3:0]  d_aluc,
    input  logic [31:0] d_qa,
    input  logic [31:0] d_qb,
    input  logic [31:0] d_imm,
    input  logic [31:0] d_pc4,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [4:0]  d_rn,
    input  logic        m_wreg,
    input  logic        m_valid,
    input  logic [4:0]  m_rn,
    input  logic [31:0] m_fwd_data,
    input  logic        w_wreg,
    input  logic [4:0]  w_rn,
    input  logic [31:0] w_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  e_aluc,
    output logic        e_wreg,
    output logic        e_m2reg,
    output logic        e_wmem,
    output logic        e_jal,
    output logic        e_valid,
    output logic [4:0]  e_rn,
    output logic [31:0] e_store_data,
    output logic [31:0] e_pc4
);

    typedef struct packed {
        logic        valid;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic        aluimm;
        logic        shift;
        logic        jal;
        logic [3:0]  aluc;
        logic [31:0] qa;
        logic [31:0] qb;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rn;
    } id_ex_t;

    id_ex_t      idex_d;
    id_ex_t      idex_q;
    id_ex_t      d_in;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    always_comb begin
        d_in.valid  = d_valid;
        d_in.wreg   = d_wreg;
        d_in.m2reg  = d_m2reg;
        d_in.wmem   = d_wmem;
        d_in.aluimm = d_aluimm;
        d_in.shift  = d_shift;
        d_in.jal    = d_jal;
        d_in.aluc   = d_aluc;
        d_in.qa     = d_qa;
        d_in.qb     = d_qb;
        d_in.imm    = d_imm;
        d_in.pc4    = d_pc4;
        d_in.rs     = d_rs;
        d_in.rt     = d_rt;
        d_in.rn     = d_rn;
    end

    // Flush beats stall so a bubble always lands.
    always_comb begin
        idex_d = idex_q;
        if (flush)
            idex_d = '0;
        else if (!stall)
            idex_d = d_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            idex_q <= '0;
        else
            idex_q <= idex_d;
    end

    // MEM outranks WB; $0 is never forwarded.
    always_comb begin
        fwd_rs = idex_q.qa;
        if (m_valid && m_wreg && m_rn == idex_q.rs && idex_q.rs != 5'd0)
            fwd_rs = m_fwd_data;
        else if (w_wreg && w_rn == idex_q.rs && idex_q.rs != 5'd0)
            fwd_rs = w_data;
    end

    always_comb begin
        fwd_rt = idex_q.qb;
        if (m_valid && m_wreg && m_rn == idex_q.rt && idex_q.rt != 5'd0)
            fwd_rt = m_fwd_data;
        else if (w_wreg && w_rn == idex_q.rt && idex_q.rt != 5'd0)
            fwd_rt = w_data;
    end

    assign alu_a = idex_q.shift ? {27'b0, idex_q.imm[10:6]} : fwd_rs;
    assign alu_b = idex_q.aluimm ? idex_q.imm : fwd_rt;

    assign e_store_data = fwd_rt;
    assign e_aluc       = idex_q.aluc;
    assign e_rn         = idex_q.rn;
    assign e_pc4        = idex_q.pc4;
    assign e_valid      = idex_q.valid;
    assign e_wreg       = idex_q.wreg  & idex_q.valid;
    assign e_m2reg      = idex_q.m2reg & idex_q.valid;
    assign e_wmem       = idex_q.wmem  & idex_q.valid;
    assign e_jal        = idex_q.jal   & idex_q.valid;

endmodule

// File: tb/tb_exe_operand_stage.sv
// Directed bench for exe_operand_stage: reset, forwarding,
// operand selection, control gating, stall and flush.
module tb_exe_operand_stage;

    logic        clock = 1'b0;
    logic        reset, stall, flush;
    logic        d_valid, d_wreg, d_m2reg, d_wmem;
    logic        d_aluimm, d_shift, d_jal;
    logic [3:0]  d_aluc;
    logic [31:0] d_qa, d_qb, d_imm, d_pc4;
    logic [4:0]  d_rs, d_rt, d_rn;
    logic        m_wreg, m_valid;
    logic [4:0]  m_rn;
    logic [31:0] m_fwd_data;
    logic        w_wreg;
    logic [4:0]  w_rn;
    logic [31:0] w_data;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  e_aluc;
    logic        e_wreg, e_m2reg, e_wmem, e_jal, e_valid;
    logic [4:0]  e_rn;
    logic [31:0] e_store_data, e_pc4;

    int tests = 0;
    int fails = 0;

    exe_operand_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .d_valid(d_valid), .d_wreg(d_wreg), .d_m2reg(d_m2reg),
        .d_wmem(d_wmem), .d_aluimm(d_aluimm), .d_shift(d_shift),
        .d_jal(d_jal), .d_aluc(d_aluc), .d_qa(d_qa), .d_qb(d_qb),
        .d_imm(d_imm), .d_pc4(d_pc4), .d_rs(d_rs), .d_rt(d_rt),
        .d_rn(d_rn), .m_wreg(m_wreg), .m_valid(m_valid), .m_rn(m_rn),
        .m_fwd_data(m_fwd_data), .w_wreg(w_wreg), .w_rn(w_rn),
        .w_data(w_data), .alu_a(alu_a), .alu_b(alu_b),
        .e_aluc(e_aluc), .e_wreg(e_wreg), .e_m2reg(e_m2reg),
        .e_wmem(e_wmem), .e_jal(e_jal), .e_valid(e_valid),
        .e_rn(e_rn), .e_store_data(e_store_data), .e_pc4(e_pc4)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_d();
        d_valid = 0; d_wreg = 0; d_m2reg = 0; d_wmem = 0;
        d_aluimm = 0; d_shift = 0; d_jal = 0; d_aluc = 4'h0;
        d_qa = 0; d_qb = 0; d_imm = 0; d_pc4 = 0;
        d_rs = 0; d_rt = 0; d_rn = 0;
    endtask

    task automatic clr_fwd();
        m_wreg = 0; m_valid = 0; m_rn = 0; m_fwd_data = 0;
        w_wreg = 0; w_rn = 0; w_data = 0;
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0;
        clr_d();
        clr_fwd();
        #3;
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_aluc", {28'h0, e_aluc}, 32'h0);
        chk("rst_valid", {31'h0, e_valid}, 32'h0);
        tick();
        reset = 0;

        // add r3, r1, r2
        d_valid = 1; d_wreg = 1; d_aluc = 4'h0;
        d_rs = 1; d_qa = 5; d_rt = 2; d_qb = 7; d_rn = 3;
        d_pc4 = 32'h40;
        tick();
        chk("add_a", alu_a, 32'd5);
        chk("add_b", alu_b, 32'd7);
        chk("add_wreg", {31'h0, e_wreg}, 32'h1);
        chk("add_rn", {27'h0, e_rn}, 32'd3);
        chk("add_pc4", e_pc4, 32'h40);

        // async reset between edges
        #2 reset = 1;
        #1;
        chk("mid_rst_a", alu_a, 32'h0);
        chk("mid_rst_wreg", {31'h0, e_wreg}, 32'h0);
        chk("mid_rst_pc4", e_pc4, 32'h0);
        reset = 0;

        // MEM forward to rs
        clr_d();
        d_valid = 1; d_wreg = 1; d_rs = 3; d_qa = 1; d_rn = 5;
        tick();
        chk("nofwd_a", alu_a, 32'd1);
        m_valid = 1; m_wreg = 1; m_rn = 3; m_fwd_data = 32'hDEAD;
        #1;
        chk("mem_fwd_a", alu_a, 32'hDEAD);
        m_valid = 0;
        #1;
        chk("mem_inval_a", alu_a, 32'd1);
        m_valid = 1;

        // $0 never forwarded
        clr_d();
        d_valid = 1; d_rs = 0; d_qa = 0;
        tick();
        m_rn = 0;
        w_wreg = 1; w_rn = 0; w_data = 32'h1234;
        #1;
        chk("zero_nofwd", alu_a, 32'h0);
        clr_fwd();

        // MEM over WB priority on rt
        clr_d();
        d_valid = 1; d_rt = 4; d_qb = 32'h44;
        tick();
        m_valid = 1; m_wreg = 1; m_rn = 4; m_fwd_data = 32'h11;
        w_wreg = 1; w_rn = 4; w_data = 32'h22;
        #1;
        chk("prio_mem", alu_b, 32'h11);
        chk("prio_store", e_store_data, 32'h11);
        m_wreg = 0;
        #1;
        chk("prio_wb", alu_b, 32'h22);
        w_wreg = 0;
        #1;
        chk("prio_none", alu_b, 32'h44);
        clr_fwd();

        // sll: sa=5, rt from WB
        clr_d();
        d_valid = 1; d_wreg = 1; d_shift = 1; d_aluc = 4'h3;
        d_imm = 32'h0000_0140; d_rs = 1; d_qa = 32'hFFFF;
        d_rt = 6; d_qb = 0; d_rn = 7;
        tick();
        w_wreg = 1; w_rn = 6; w_data = 32'h3;
        #1;
        chk("sll_a", alu_a, 32'd5);
        chk("sll_b", alu_b, 32'd3);
        chk("sll_aluc", {28'h0, e_aluc}, 32'h3);
        clr_fwd();

        // sw: imm on b, store data forwarded
        clr_d();
        d_valid = 1; d_wmem = 1; d_aluimm = 1; d_imm = 32'd8;
        d_rt = 7; d_qb = 0; d_rs = 2; d_qa = 32'h100;
        tick();
        w_wreg = 1; w_rn = 7; w_data = 32'h99;
        #1;
        chk("sw_b", alu_b, 32'd8);
        chk("sw_store", e_store_data, 32'h99);
        chk("sw_wmem", {31'h0, e_wmem}, 32'h1);
        chk("sw_wreg", {31'h0, e_wreg}, 32'h0);
        clr_fwd();

        // controls gated by valid
        clr_d();
        d_valid = 0; d_wreg = 1; d_m2reg = 1; d_wmem = 1; d_jal = 1;
        d_rn = 31;
        tick();
        chk("inv_ctl", {28'h0, e_wreg, e_m2reg, e_wmem, e_jal},
            32'h0);
        chk("inv_rn", {27'h0, e_rn}, 32'd31);
        d_valid = 1;
        tick();
        chk("val_ctl", {28'h0, e_wreg, e_m2reg, e_wmem, e_jal},
            32'hF);

        // instruction A, then stall 3 cycles
        clr_d();
        d_valid = 1; d_wreg = 1; d_aluc = 4'h3; d_rs = 1;
        d_qa = 32'hA1; d_rt = 2; d_qb = 32'hA2; d_rn = 9;
        d_pc4 = 32'h100;
        tick();
        chk("A_a", alu_a, 32'hA1);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            d_qa = 32'h55 + i; d_qb = 32'h66 + i; d_rn = 5'd12;
            d_pc4 = 32'h200; d_aluc = 4'h7;
            tick();
            if (i == 1) begin
                m_valid = 1; m_wreg = 1; m_rn = 1;
                m_fwd_data = 32'h77;
                #1;
                chk("stall_fwd_a", alu_a, 32'h77);
                clr_fwd();
                #1;
            end
            chk("stall_a", alu_a, 32'hA1);
            chk("stall_b", alu_b, 32'hA2);
            chk("stall_rn", {27'h0, e_rn}, 32'd9);
            chk("stall_pc4", e_pc4, 32'h100);
            chk("stall_aluc", {28'h0, e_aluc}, 32'h3);
        end

        // flush with stall: bubble
        flush = 1;
        d_valid = 1; d_wreg = 1; d_wmem = 1;
        tick();
        chk("flush_valid", {31'h0, e_valid}, 32'h0);
        chk("flush_wreg", {31'h0, e_wreg}, 32'h0);
        chk("flush_wmem", {31'h0, e_wmem}, 32'h0);
        chk("flush_a", alu_a, 32'h0);
        flush = 0;

        // load B, then reset in the middle of a stall
        stall = 0;
        clr_d();
        d_valid = 1; d_wreg = 1; d_rn = 20; d_pc4 = 32'h300;
        tick();
        chk("B_rn", {27'h0, e_rn}, 32'd20);
        stall = 1;
        #2 reset = 1;
        #1;
        chk("stall_rst_valid", {31'h0, e_valid}, 32'h0);
        chk("stall_rst_rn", {27'h0, e_rn}, 32'd0);
        reset = 0;
        tick();
        chk("rst_hold", {31'h0, e_valid}, 32'h0);
        stall = 0;
        tick();
        chk("rel_valid", {31'h0, e_valid}, 32'h1);
        chk("rel_pc4", e_pc4, 32'h300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exe_operand_stage.md
# exe_operand_stage

ID/EX pipeline register plus EX-stage operand network for the pipelined CPU. Captures the decoded instruction from ID on each clock, resolves RAW hazards by forwarding from the MEM and WB stages, and drives the two 32-bit operands and 4-bit opcode straight into the combinational ALU. Also carries the control bits and store data that the EX/MEM register needs downstream.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register numbers, 4-bit aluc).
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears every register
- stall  in  1  hold all ID/EX registers this edge
- flush  in  1  load a bubble this edge
- d_valid, d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal  in  1 each  decoded controls from ID
- d_aluc  in  4  ALU opcode
- d_qa, d_qb  in  32  register-file reads for rs, rt
- d_imm  in  32  extended immediate (ID already sign/zero-extends)
- d_pc4  in  32  PC+4 of the instruction
- d_rs, d_rt, d_rn  in  5  source and destination register numbers
- m_wreg, m_valid  in  1  MEM-stage write intent
- m_rn  in  5  MEM-stage destination; m_fwd_data  in  32  MEM-stage result
- w_wreg  in  1; w_rn  in  5; w_data  in  32  WB-stage write port
- alu_a, alu_b  out  32  ALU operands
- e_aluc  out  4  ALU opcode
- e_wreg, e_m2reg, e_wmem, e_jal, e_valid  out  1  controls to EX/MEM
- e_rn  out  5; e_store_data  out  32 (forwarded rt value); e_pc4  out  32

## Operation
- Register set R: valid, wreg, m2reg, wmem, aluimm, shift, jal, aluc, qa, qb, imm, pc4, rs, rt, rn.
- Edge update priority: reset > flush > stall > load.
  - flush: valid, wreg, wmem, m2reg, jal cleared; datapath fields don't-care (clear to 0).
  - stall (no flush): all of R holds.
  - otherwise: R <= d_* inputs.
- Forwarding (combinational, per source s in {rs, rt}, with q = qa/qb):
  - MEM hit: m_valid & m_wreg & m_rn == s & s != 0 -> m_fwd_data.
  - else WB hit: w_wreg & w_rn == s & s != 0 -> w_data.
  - else captured q. MEM has priority over WB when both match.
- Operand selection:
  - alu_a = shift ? {27'b0, imm[10:6]} : fwd_rs (ALU shifts compute b << a, so sa is zero-extended).
  - alu_b = aluimm ? imm : fwd_rt. LUI uses aluimm=1; ALU performs the << 16.
  - e_store_data = fwd_rt always, independent of aluimm.
- e_wreg = wreg & valid; e_wmem = wmem & valid; e_m2reg, e_jal likewise gated. e_aluc, e_rn, e_pc4 are direct register outputs.
- Register $0 is never forwarded; a $0 source reads the captured q, which is 0.

## Timing
- Reset: all outputs 0 asynchronously. alu_a = alu_b = 0 and e_aluc = 0000 (ADD), so the ALU z flag is 1.
- Latency: d_* sampled at edge N appear on outputs after edge N. Forwarding is same-cycle combinational from m_*/w_* to alu_a/alu_b.
- Stall held for k cycles: outputs stay constant except forwarded values, which track m_*/w_* every cycle.
- Flush together with stall: flush wins; a bubble is loaded.
- Reset asserted mid-stall: registers clear immediately. After release, the first edge without stall or flush loads d_*.
- A load-use hazard (MEM load whose data is not yet valid) is detected upstream. Upstream must stall and flush this stage; this block performs no hazard detection.

## Test plan
- Reset: assert reset between edges -> all outputs 0 immediately. Release, load add rs=1 (qa=5), rt=2 (qb=7), aluc=0000 -> next cycle alu_a=5, alu_b=7, e_wreg=1.
- MEM forward: EX rs=3 (qa=1), m_valid=m_wreg=1, m_rn=3, m_fwd_data=0xDEAD -> alu_a=0xDEAD. Same case with m_rn=0 and rs=0 -> no forward, alu_a=0.
- Priority: rt=4, MEM (0x11) and WB (0x22) both target r4 -> alu_b=0x11. Drop m_wreg -> alu_b=0x22.
- Immediate/shift: sll with imm[10:6]=5 and rt forwarded from WB 0x3 -> alu_a=5, alu_b=3. sw with aluimm=1, imm=8, rt forwarded 0x99 -> alu_b=8, e_store_data=0x99.
- Stall/flush: load instr A, hold stall 3 cycles while changing d_* -> outputs keep A. Assert flush and stall together -> e_valid=0, e_wreg=0, e_wmem=0 next cycle.
